// File: rtl/jtframe_romslot_cache.sv
// Two-entry fully associative tag/data store for the ROM slot.
// Handles lookup, LRU tracking and the single fill write port.
module jtframe_romslot_cache #(
    parameter int TW = 17
) (
    input  logic          rst_n,
    input  logic          clk,
    input  logic          clr,
    input  logic          lookup_en,
    input  logic [TW-1:0] lookup_tag,
    output logic          hit,
    output logic [15:0]   hit_word,
    input  logic          wr_en,
    input  logic [TW-1:0] wr_tag,
    input  logic [15:0]   wr_data
);

    logic [1:0]    valid_q, valid_d;
    logic [TW-1:0] tag_q  [2];
    logic [TW-1:0] tag_d  [2];
    logic [15:0]   word_q [2];
    logic [15:0]   word_d [2];
    logic          lru_q, lru_d;
    logic          match0_s, match1_s, hit_way_s, victim_s;

    // Lookup against registered state; entry 0 wins a (theoretical) double match.
    always_comb begin
        match0_s  = valid_q[0] && (tag_q[0] == lookup_tag);
        match1_s  = valid_q[1] && (tag_q[1] == lookup_tag);
        hit       = lookup_en && (match0_s || match1_s);
        hit_way_s = match0_s ? 1'b0 : 1'b1;
        hit_word  = match0_s ? word_q[0] : word_q[1];
        // A same-cycle hit protects its entry from being overwritten by a fill.
        victim_s  = hit ? ~hit_way_s : lru_q;
    end

    // Next-state for valid bits, tags, data words and the LRU pointer.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        word_d  = word_q;
        lru_d   = lru_q;
        if (clr) begin
            valid_d = 2'b00;
            lru_d   = 1'b0;
        end else if (wr_en) begin
            valid_d[victim_s] = 1'b1;
            tag_d[victim_s]   = wr_tag;
            word_d[victim_s]  = wr_data;
            lru_d             = ~victim_s;
        end else if (hit) begin
            lru_d = ~hit_way_s;
        end else begin
            lru_d = lru_q;
        end
    end

    // Cache state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 2'b00;
            tag_q   <= '{default: '0};
            word_q  <= '{default: '0};
            lru_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            word_q  <= word_d;
            lru_q   <= lru_d;
        end
    end

endmodule

// File: rtl/jtframe_romslot.sv
// ROM slot: a 2-entry word cache in front of a 16-bit SDRAM port.
// Hits answer combinationally; misses run a one-word fetch through the FSM.
module jtframe_romslot #(
    parameter int AW = 18,
    parameter int DW = 8
) (
    input  logic          rst_n,
    input  logic          clk,
    input  logic          clr,
    input  logic [AW-1:0] addr,
    input  logic          addr_ok,
    output logic [DW-1:0] data,
    output logic          data_ok,
    output logic          sdram_req,
    output logic [AW-2:0] sdram_addr,
    input  logic          sdram_ack,
    input  logic [15:0]   sdram_din,
    input  logic          sdram_dok
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          sdram_req_q, sdram_req_d;
    logic [AW-2:0] sdram_addr_q, sdram_addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          hit_s, fill_s;
    logic [15:0]   hit_word_s;
    logic [DW-1:0] sel_s;

    jtframe_romslot_cache #(.TW(AW-1)) u_cache (
        .rst_n      (rst_n),
        .clk        (clk),
        .clr        (clr),
        .lookup_en  (addr_ok),
        .lookup_tag (addr[AW-1:1]),
        .hit        (hit_s),
        .hit_word   (hit_word_s),
        .wr_en      (fill_s),
        .wr_tag     (sdram_addr_q),
        .wr_data    (sdram_din)
    );

    generate
        if (DW == 8) begin : g_byte
            assign sel_s = addr[0] ? hit_word_s[15:8] : hit_word_s[7:0];
        end else begin : g_word
            assign sel_s = hit_word_s[DW-1:0];
        end
    endgenerate

    // Fetch FSM; clr aborts any fetch and suppresses the fill write.
    always_comb begin
        state_d      = state_q;
        sdram_addr_d = sdram_addr_q;
        fill_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!clr && addr_ok && !hit_s) begin
                    state_d      = ST_REQ;
                    sdram_addr_d = addr[AW-1:1];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (clr) begin
                    state_d = ST_IDLE;
                end else if (sdram_ack && sdram_dok) begin
                    fill_s  = 1'b1;
                    state_d = ST_IDLE;
                end else if (sdram_ack) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (clr) begin
                    state_d = ST_IDLE;
                end else if (sdram_dok) begin
                    fill_s  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        sdram_req_d = (state_d == ST_REQ);
        data_d      = hit_s ? sel_s : data_q;
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sdram_req_q  <= 1'b0;
            sdram_addr_q <= '0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            sdram_req_q  <= sdram_req_d;
            sdram_addr_q <= sdram_addr_d;
            data_q       <= data_d;
        end
    end

    assign sdram_req  = sdram_req_q;
    assign sdram_addr = sdram_addr_q;
    assign data       = data_d;
    assign data_ok    = hit_s;

endmodule

// File: tb/tb_jtframe_romslot.sv
// Directed bench for jtframe_romslot with a recency-list cache model
// compared against the DUT on every falling clock edge.
module tb_jtframe_romslot;

    localparam int AW = 18;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          clr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          addr_ok = 1'b0;
    logic [DW-1:0] data;
    logic          data_ok;
    logic          sdram_req;
    logic [AW-2:0] sdram_addr;
    logic          sdram_ack = 1'b0;
    logic [15:0]   sdram_din = 16'h0000;
    logic          sdram_dok = 1'b0;

    int compared = 0;
    int mismatched = 0;

    jtframe_romslot #(.AW(AW), .DW(DW)) dut (
        .rst_n      (rst_n),
        .clk        (clk),
        .clr        (clr),
        .addr       (addr),
        .addr_ok    (addr_ok),
        .data       (data),
        .data_ok    (data_ok),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .sdram_din  (sdram_din),
        .sdram_dok  (sdram_dok)
    );

    always #5 clk = ~clk;

    // Model: most-recently-used entry at the front, at most two entries.
    logic [AW-2:0] m_tags[$];
    logic [15:0]   m_words[$];
    bit            m_pend = 1'b0;
    bit            m_wait = 1'b0;
    logic [AW-2:0] m_addr = '0;
    logic [DW-1:0] m_last = '0;
    int            m_idx;
    bit            m_hit, m_fill;
    logic [AW-2:0] m_t;
    logic [15:0]   m_w;

    function automatic int m_find(input logic [AW-2:0] t);
        for (int i = 0; i < m_tags.size(); i++) begin
            if (m_tags[i] == t) return i;
        end
        return -1;
    endfunction

    function automatic logic [7:0] m_byte(input logic [15:0] w, input logic b0);
        return b0 ? w[15:8] : w[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_tags.delete();
                m_words.delete();
                m_pend = 1'b0;
                m_wait = 1'b0;
                m_addr = '0;
                m_last = '0;
            end else begin
                m_idx = addr_ok ? m_find(addr[AW-1:1]) : -1;
                m_hit = (m_idx >= 0);
                if (m_hit) m_last = m_byte(m_words[m_idx], addr[0]);
                if (clr) begin
                    m_tags.delete();
                    m_words.delete();
                    m_pend = 1'b0;
                end else begin
                    m_fill = m_pend && sdram_dok && (m_wait || sdram_ack);
                    if (m_hit) begin
                        m_t = m_tags[m_idx];
                        m_w = m_words[m_idx];
                        m_tags.delete(m_idx);
                        m_words.delete(m_idx);
                        m_tags.push_front(m_t);
                        m_words.push_front(m_w);
                    end
                    if (m_fill) begin
                        m_tags.push_front(m_addr);
                        m_words.push_front(sdram_din);
                        if (m_tags.size() > 2) begin
                            void'(m_tags.pop_back());
                            void'(m_words.pop_back());
                        end
                        m_pend = 1'b0;
                    end else if (m_pend) begin
                        if (!m_wait && sdram_ack) m_wait = 1'b1;
                    end else if (addr_ok && !m_hit) begin
                        m_pend = 1'b1;
                        m_wait = 1'b0;
                        m_addr = addr[AW-1:1];
                    end
                end
            end
        end
    end

    // Per-cycle compare of all outputs against the model.
    initial begin
        int  ci;
        logic [DW-1:0] exp_data;
        forever begin
            @(negedge clk);
            ci = addr_ok ? m_find(addr[AW-1:1]) : -1;
            exp_data = (ci >= 0) ? m_byte(m_words[ci], addr[0]) : m_last;
            check("model_data_ok", {31'd0, data_ok}, {31'd0, ci >= 0});
            check("model_data", {24'd0, data}, {24'd0, exp_data});
            check("model_req", {31'd0, sdram_req}, {31'd0, m_pend && !m_wait});
            check("model_sdram_addr", {15'd0, sdram_addr}, {15'd0, m_addr});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!sdram_req && n < 20) begin
            step();
            n++;
        end
        check("req_timeout", {31'd0, sdram_req}, 32'd1);
    endtask

    task automatic do_fill(input logic [15:0] v);
        wait_req();
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        sdram_dok = 1'b1;
        sdram_din = v;
        step();
        sdram_dok = 1'b0;
        sdram_din = 16'h0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        rst_n = 1'b0;
        addr = 18'h00101;
        addr_ok = 1'b1;
        repeat (3) step();
        check("rst_data_ok", {31'd0, data_ok}, 32'd0);
        check("rst_req", {31'd0, sdram_req}, 32'd0);
        check("rst_data", {24'd0, data}, 32'd0);
        check("rst_sdram_addr", {15'd0, sdram_addr}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("first_after_rst", {31'd0, data_ok}, 32'd0);

        // Cold miss then fill
        step();
        check("cold_req", {31'd0, sdram_req}, 32'd1);
        check("cold_addr", {15'd0, sdram_addr}, 32'h00080);
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        check("cold_req_drop", {31'd0, sdram_req}, 32'd0);
        sdram_dok = 1'b1;
        sdram_din = 16'hBEEF;
        step();
        sdram_dok = 1'b0;
        sdram_din = 16'h0000;
        check("cold_data_ok", {31'd0, data_ok}, 32'd1);
        check("cold_data", {24'd0, data}, 32'h000000BE);

        // Hit on the low byte of the same word
        addr = 18'h00100;
        #1;
        check("hit_data_ok", {31'd0, data_ok}, 32'd1);
        check("hit_data", {24'd0, data}, 32'h000000EF);
        step();
        check("hit_no_req", {31'd0, sdram_req}, 32'd0);

        // LRU replacement
        clr = 1'b1;
        step();
        clr = 1'b0;
        addr = 18'h00020;
        #1;
        check("after_clr_data_ok", {31'd0, data_ok}, 32'd0);
        do_fill(16'h1111);
        check("lru_fill10", {24'd0, data}, 32'h00000011);
        addr = 18'h00040;
        do_fill(16'h2222);
        addr = 18'h00020;
        #1;
        check("lru_hit10", {31'd0, data_ok}, 32'd1);
        step();
        addr = 18'h00060;
        do_fill(16'h3333);
        check("lru_fill30", {24'd0, data}, 32'h00000033);
        addr = 18'h00020;
        #1;
        check("lru_keep10", {31'd0, data_ok}, 32'd1);
        addr = 18'h00040;
        #1;
        check("lru_evict20", {31'd0, data_ok}, 32'd0);
        addr_ok = 1'b0;
        step();
        step();

        // Address change mid-fetch
        clr = 1'b1;
        step();
        clr = 1'b0;
        addr = 18'h00040;
        addr_ok = 1'b1;
        step();
        check("mid_addr_req", {15'd0, sdram_addr}, 32'h00020);
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        addr = 18'h00050;
        step();
        check("mid_addr_hold", {15'd0, sdram_addr}, 32'h00020);
        check("mid_wait_req", {31'd0, sdram_req}, 32'd0);
        sdram_dok = 1'b1;
        sdram_din = 16'h4444;
        step();
        sdram_dok = 1'b0;
        check("mid_new_miss", {31'd0, data_ok}, 32'd0);
        step();
        check("mid_new_req", {31'd0, sdram_req}, 32'd1);
        check("mid_new_addr", {15'd0, sdram_addr}, 32'h00028);
        do_fill(16'h5555);
        check("mid_new_data", {24'd0, data}, 32'h00000055);

        // clr during WAIT discards the late data
        addr = 18'h00070;
        step();
        check("clrw_req", {31'd0, sdram_req}, 32'd1);
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clrw_req_drop", {31'd0, sdram_req}, 32'd0);
        sdram_dok = 1'b1;
        sdram_din = 16'h1234;
        step();
        sdram_dok = 1'b0;
        check("clrw_discard", {31'd0, data_ok}, 32'd0);
        check("clrw_miss_again", {31'd0, sdram_req}, 32'd1);

        // clr coinciding with dok
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        clr = 1'b1;
        sdram_dok = 1'b1;
        sdram_din = 16'h9999;
        step();
        clr = 1'b0;
        sdram_dok = 1'b0;
        check("clr_beats_dok", {31'd0, data_ok}, 32'd0);
        do_fill(16'h7777);
        check("refill_data", {24'd0, data}, 32'h00000077);

        // Reset in REQ
        addr = 18'h00090;
        step();
        check("rstreq_req", {31'd0, sdram_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstreq_req_drop", {31'd0, sdram_req}, 32'd0);
        addr = 18'h00070;
        #1;
        check("rstreq_valid_clr", {31'd0, data_ok}, 32'd0);
        sdram_dok = 1'b1;
        step();
        sdram_dok = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        check("rstreq_first", {31'd0, data_ok}, 32'd0);
        step();
        check("rstreq_miss", {31'd0, sdram_req}, 32'd1);
        do_fill(16'h6677);
        check("rstreq_refill", {24'd0, data}, 32'h00000077);

        addr_ok = 1'b0;
        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
